// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DividendWDefault = 8;
  localparam int unsigned DivisorWDefault  = 4;
  localparam int unsigned CntWDefault      = $clog2(DividendWDefault);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_sub_step.sv
// Combinational trial subtractor: minuend - subtrahend as a ripple of full adders.
module div_sub_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned Width = DivisorWDefault + 1
) (
  input  logic [Width-1:0] minuend_i,
  input  logic [Width-1:0] subtrahend_i,
  output logic [Width-1:0] diff_o,
  output logic             nonneg_o
);

  logic [Width:0] carry;

  // a + ~b + 1; the final carry is set exactly when no borrow occurred.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < Width; i++) begin : g_fa
    full_adder u_fa (
      .a_i (minuend_i[i]),
      .b_i (~subtrahend_i[i]),
      .c_i (carry[i]),
      .s_o (diff_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign nonneg_o = carry[Width];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DividendWDefault,
  parameter int unsigned DIVISOR_W  = DivisorWDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  // Holds the restored partial remainder; its top bit would always be zero.
  logic [DIVISOR_W-1:0]  pr_q, pr_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic                  dz_work_q, dz_work_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dz_q, dz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W:0] trial_a;
  logic [DIVISOR_W:0] trial_diff;
  logic               trial_nonneg;

  assign trial_a = {pr_q, dvd_q[DIVIDEND_W-1]};

  div_sub_step #(
    .Width (DIVISOR_W + 1)
  ) u_sub_step (
    .minuend_i    (trial_a),
    .subtrahend_i ({1'b0, dvs_q}),
    .diff_o       (trial_diff),
    .nonneg_o     (trial_nonneg)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    dz_work_d   = dz_work_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          busy_d = 1'b1;
          dvd_d  = dividend_i;
          dvs_d  = divisor_i;
          if (divisor_i == '0) begin
            state_d   = StDone;
            quo_d     = '1;
            pr_d      = dividend_i[DIVISOR_W-1:0];
            dz_work_d = 1'b1;
          end else begin
            state_d   = StCalc;
            cnt_d     = CntW'(DIVIDEND_W - 1);
            pr_d      = '0;
            quo_d     = '0;
            dz_work_d = 1'b0;
          end
        end
      end
      StCalc: begin
        pr_d  = trial_nonneg ? trial_diff[DIVISOR_W-1:0] : trial_a[DIVISOR_W-1:0];
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        quo_d = {quo_q[DIVIDEND_W-2:0], trial_nonneg};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Publish the finished result together with done.
        quotient_d  = quo_q;
        remainder_d = pr_q;
        dz_d        = dz_work_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      dz_work_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      dz_work_q   <= dz_work_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: random and directed stimulus against a plain
// arithmetic reference, with a decoupled monitor checking every done pulse.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int cyc       = 0;
  int n_cmp     = 0;
  int n_bad     = 0;
  int next_free = 0;
  bit prev_done = 1'b0;

  seq_divider #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_div_by_zero"}, 32'(dz), 32'd0);
  endtask

  // Issue one division at a negedge once the model says the divider is free.
  task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit hold);
    exp_t e;
    int   lat;
    while (cyc < next_free) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.a = a;
    e.b = b;
    if (b == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = 4'(int'(a) % 16);
      e.dz = 1'b1;
      lat  = 1;
    end else begin
      e.q  = 8'(int'(a) / int'(b));
      e.r  = 4'(int'(a) % int'(b));
      e.dz = 1'b0;
      lat  = 9;
    end
    e.due     = cyc + 1 + lat;
    next_free = e.due;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) begin
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("done_one_cycle", 32'(prev_done), 32'd0);
      chk("busy_done_exclusive", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none (cycle %0d)",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.due));
        chk("quotient", 32'(quotient), 32'(mon_e.q));
        chk("remainder", 32'(remainder), 32'(mon_e.r));
        chk("div_by_zero", 32'(dz), 32'(mon_e.dz));
        if (mon_e.b != 4'd0) begin
          chk("identity", 32'(int'(quotient) * int'(mon_e.b) + int'(remainder)), 32'(mon_e.a));
          chk("rem_lt_div", 32'(remainder < mon_e.b), 32'd1);
        end
      end
    end
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    logic [3:0] rb;
    rst      = 1'b1;
    start    = 1'($urandom);
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    @(negedge clk);
    check_zero("reset1");
    start    = 1'($urandom);
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    @(negedge clk);
    check_zero("reset2");
    rst       = 1'b0;
    start     = 1'b0;
    next_free = cyc;

    issue(8'd225, 4'd15, 1'b0);
    issue(8'd200, 4'd7, 1'b0);
    issue(8'd143, 4'd11, 1'b0);
    issue(8'd0, 4'd3, 1'b0);
    issue(8'd5, 4'd0, 1'b0);
    issue(8'd9, 4'd2, 1'b0);

    // A start pulse with other operands while busy must be ignored.
    issue(8'd100, 4'd9, 1'b0);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd37;
    divisor  = 4'd5;
    @(negedge clk);
    start = 1'b0;

    // start held high: re-accepted as soon as the divider returns to idle.
    issue(8'd77, 4'd6, 1'b1);
    issue(8'd250, 4'd13, 1'b1);
    issue(8'd18, 4'd0, 1'b1);
    issue(8'd31, 4'd4, 1'b1);
    start = 1'b0;

    // Reset in the middle of a calculation discards it and zeroes the outputs.
    issue(8'd180, 4'd7, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check_zero("mid_reset");
    rst       = 1'b0;
    next_free = cyc;

    repeat (60) begin
      ra = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
      issue(ra, rb, 1'b0);
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b), 1'b0);
      end
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
